// File: rtl/shared_adder_sequencer_pkg.sv
// Shared types and defaults for the slice-serial shared adder sequencer.
package shared_adder_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned SLICE_W     = 4;
    localparam int unsigned DEF_N_REQ   = 2;
    localparam int unsigned DEF_NIBBLES = 4;

endpackage

// File: rtl/shared_adder_sequencer_rca.sv
// 4-bit ripple-carry adder used as the single shared slice datapath.
module Day32_Ripple_Carry_Adder
    import shared_adder_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] c;

    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/shared_adder_sequencer.sv
// Round-robin arbitrated, nibble-serial adder shared by N_REQ requesters.
module shared_adder_sequencer
    import shared_adder_sequencer_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned NIBBLES = DEF_NIBBLES,
    localparam int unsigned W      = SLICE_W * NIBBLES,
    localparam int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_cout
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic               found;
    logic [ID_W-1:0]    gnt;
    logic [SLICE_W-1:0] add_a, add_b, add_sum;
    logic               add_cout;

    assign add_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign add_b = b_q[idx_q*SLICE_W +: SLICE_W];

    Day32_Ripple_Carry_Adder u_rca (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!found && req_valid[(32'(rr_q) + k) % N_REQ]) begin
                found = 1'b1;
                gnt   = ID_W'((32'(rr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_id_d   = rsp_id_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[gnt] = 1'b1;
                    a_d     = req_a[gnt*W +: W];
                    b_d     = req_b[gnt*W +: W];
                    carry_d = req_cin[gnt];
                    id_d    = gnt;
                    rr_d    = gnt;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[idx_q*SLICE_W +: SLICE_W] = add_sum;
                carry_d = add_cout;
                idx_d   = IDX_W'(idx_q + 1'b1);
                // Response registers load only on the final slice so they hold outside RESP.
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    idx_d      = '0;
                    rsp_sum_d  = acc_d;
                    rsp_cout_d = add_cout;
                    rsp_id_d   = id_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/shared_adder_sequencer.md
SHARED_ADDER_SEQUENCER -- requirements
Module: shared_adder_sequencer

Interface
REQ-001 SHALL have parameter N_REQ, default 2: number of requesters sharing the adder; range 2..4.
REQ-002 SHALL have parameter NIBBLES, default 4: operand width in 4-bit slices; W = 4*NIBBLES.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester operation valid.
REQ-007 SHALL have port req_ready, output, N_REQ: per-requester accept.
REQ-008 SHALL have port req_a, input, N_REQ*W: operand A; requester i occupies bits [i*W +: W].
REQ-009 SHALL have port req_b, input, N_REQ*W: operand B, packed as req_a.
REQ-010 SHALL have port req_cin, input, N_REQ: carry-in per requester.
REQ-011 SHALL have port rsp_valid, output, 1: result valid.
REQ-012 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port rsp_id, output, clog2(N_REQ): index of the requester that owns the result.
REQ-014 SHALL have port rsp_sum, output, W: result sum.
REQ-015 SHALL have port rsp_cout, output, 1: carry-out of the most significant slice.

Function
REQ-016 SHALL be an FSM with states IDLE, ADD and RESP.
REQ-017 In IDLE, SHALL choose a grant round-robin among asserted req_valid bits, starting from the requester after the last granted one.
REQ-018 In IDLE, SHALL assert req_ready only for the granted requester, combinationally; all other req_ready bits SHALL be 0.
REQ-019 In ADD and RESP, all req_ready bits SHALL be 0.
REQ-020 A request SHALL be accepted when req_valid[g] and req_ready[g] are both 1 on a clock edge.
REQ-021 On acceptance, SHALL latch A, B, cin and id; set slice index to 0; go to ADD.
REQ-022 On acceptance, SHALL update the round-robin pointer to g.
REQ-023 In ADD, each cycle SHALL pass slice [idx*4 +: 4] of A and B plus the carry register through one 4-bit adder.
REQ-024 In ADD, each cycle SHALL store the 4-bit sum into result slice idx, load the adder carry-out into the carry register, and increment idx.
REQ-025 After the ADD cycle with idx = NIBBLES-1, SHALL go to RESP.
REQ-026 Latency SHALL be fixed: acceptance edge at cycle T; ADD occupies cycles T+1..T+NIBBLES; rsp_valid = 1 from cycle T+NIBBLES+1.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_valid and rsp_ready are both 1 on an edge; the FSM SHALL then go to IDLE.
REQ-028 Arithmetic SHALL be modulo 2^W; rsp_cout = bit W of A + B + cin.
REQ-029 rsp_valid SHALL be 0 outside RESP.
REQ-030 rsp_sum, rsp_cout and rsp_id SHALL keep their last values outside RESP.
REQ-031 A requester that deasserts req_valid before acceptance SHALL not be served; a request held valid SHALL be granted within N_REQ arbitration rounds.
REQ-032 req_valid changing during ADD or RESP SHALL not affect the operation in flight.

Reset
REQ-033 Asserting rst_n low SHALL immediately force: state IDLE, idx 0, carry 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0.
REQ-034 Asserting rst_n low SHALL set the round-robin pointer to N_REQ-1, so requester 0 has first priority.
REQ-035 Reset during ADD or RESP SHALL discard the operation in flight; no response for it SHALL appear.

Structure
REQ-036 The shared package SHALL hold the state enum (IDLE/ADD/RESP), SLICE_W = 4, and default N_REQ/NIBBLES.
REQ-037 The block SHALL instantiate exactly one Day32_Ripple_Carry_Adder as its 4-bit slice datapath; no other adder SHALL be inferred for operand data.

Verification
REQ-038 Sum test: N_REQ=2, NIBBLES=4; req0 A=0x1234, B=0x0FCD, cin=0; accepted at T -> rsp_valid at T+5, rsp_sum=0x2201, rsp_cout=0, rsp_id=0.
REQ-039 Carry-through test: A=0xFFFF, B=0x0001, cin=0 -> sum 0x0000, cout 1; then A=0xFFFF, B=0x0000, cin=1 -> sum 0x0000, cout 1.
REQ-040 Fairness test: both requesters valid from the first cycle after reset -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-041 Back-pressure test: rsp_ready held 0 for 3 cycles in RESP -> rsp_sum/rsp_cout/rsp_id stable, req_ready=0; response completes on the first rsp_ready=1 edge.
REQ-042 Reset test: rst_n low in the 2nd ADD cycle -> outputs zero at once; after release, a new request gets a correct result with no stale carry.
REQ-043 Dropped-request test: req1 valid for one cycle while busy, then deasserted -> no grant to req1 and no response with rsp_id=1.
